reset_sequencer: RTL

//   Consumes the PLL lock indicator and produces staged synchronous resets for the SoC.

---
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Staged reset generator driven by the PLL lock indicator.
// Waits for a stable lock, stretches reset, then releases peripherals before the CPU core.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_CYCLES       = 48,
  parameter int STAGGER_CYCLES     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sw_reset,
  output logic       periph_reset,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_AB     = (LOCK_STABLE_CYCLES > RESET_CYCLES) ? LOCK_STABLE_CYCLES : RESET_CYCLES;
  localparam int MAX_CYCLES = (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    PERIPH    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_sync1;
  logic             r_locked_s;
  logic             r_periph_reset;
  logic             w_periph_reset_next;
  logic             r_core_reset;
  logic             w_core_reset_next;
  logic             r_ready;
  logic             w_ready_next;
  logic [7:0]       r_lock_lost_cnt;
  logic [7:0]       w_lock_lost_cnt_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1         <= 1'b0;
      r_locked_s      <= 1'b0;
      r_state         <= WAIT_LOCK;
      r_cnt           <= '0;
      r_periph_reset  <= 1'b1;
      r_core_reset    <= 1'b1;
      r_ready         <= 1'b0;
      r_lock_lost_cnt <= 8'd0;
    end else begin
      r_sync1         <= pll_locked;
      r_locked_s      <= r_sync1;
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_periph_reset  <= w_periph_reset_next;
      r_core_reset    <= w_core_reset_next;
      r_ready         <= w_ready_next;
      r_lock_lost_cnt <= w_lock_lost_cnt_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_cnt_next           = r_cnt;
    w_periph_reset_next  = r_periph_reset;
    w_core_reset_next    = r_core_reset;
    w_ready_next         = r_ready;
    w_lock_lost_cnt_next = r_lock_lost_cnt;

    // Lock loss outranks sw_reset in every state past WAIT_LOCK.
    if (r_state != WAIT_LOCK && !r_locked_s) begin
      w_state_next        = WAIT_LOCK;
      w_cnt_next          = '0;
      w_periph_reset_next = 1'b1;
      w_core_reset_next   = 1'b1;
      w_ready_next        = 1'b0;
      if (r_state == RUN && r_lock_lost_cnt != 8'hFF) begin
        w_lock_lost_cnt_next = r_lock_lost_cnt + 8'd1;
      end
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (!r_locked_s) begin
            w_cnt_next = '0;
          end else if (r_cnt == LOCK_LAST) begin
            w_state_next = STRETCH;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        STRETCH: begin
          if (sw_reset) begin
            w_cnt_next = '0;
          end else if (r_cnt == RESET_LAST) begin
            w_state_next        = PERIPH;
            w_cnt_next          = '0;
            w_periph_reset_next = 1'b0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        PERIPH: begin
          if (sw_reset) begin
            w_state_next        = STRETCH;
            w_cnt_next          = '0;
            w_periph_reset_next = 1'b1;
          end else if (r_cnt == STAGGER_LAST) begin
            w_state_next      = RUN;
            w_cnt_next        = '0;
            w_core_reset_next = 1'b0;
            w_ready_next      = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (sw_reset) begin
            w_state_next        = STRETCH;
            w_cnt_next          = '0;
            w_periph_reset_next = 1'b1;
            w_core_reset_next   = 1'b1;
            w_ready_next        = 1'b0;
          end
        end
        default: begin
          w_state_next        = WAIT_LOCK;
          w_cnt_next          = '0;
          w_periph_reset_next = 1'b1;
          w_core_reset_next   = 1'b1;
          w_ready_next        = 1'b0;
        end
      endcase
    end
  end

  assign periph_reset  = r_periph_reset;
  assign core_reset    = r_core_reset;
  assign ready         = r_ready;
  assign lock_lost_cnt = r_lock_lost_cnt;

endmodule
